// File: rtl/p_s_ctrl.sv
// Parallel-to-serial controller: ping-pong bank bookkeeping between 4-sample input beats and a serial sample stream.
// Define P_S_CTRL_BITREV_EN to emit the read index in bit-reversed order (natural-order FFT output).
module p_s_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ld_en,
  output logic       ld_bank,
  output logic [1:0] ld_idx,
  output logic       rd_en,
  output logic       rd_bank,
  output logic [3:0] rd_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_done
);

  logic       wr_bank;
  logic [1:0] wcnt;
  logic [3:0] rcnt;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic [3:0] idx_p1;

  function automatic logic [3:0] map_idx(input logic [3:0] cnt);
`ifdef P_S_CTRL_BITREV_EN
    return {cnt[0], cnt[1], cnt[2], cnt[3]};
`else
    return cnt;
`endif
  endfunction

  // Combinational handshake and strobes; in_ready is held low while reset is asserted
  always_comb begin
    in_ready = !rst && !full[wr_bank];
    ld_en    = in_valid && in_ready;
    ld_bank  = wr_bank;
    ld_idx   = wcnt;
    rd_en    = full[rd_bank] && (!out_valid || out_ready);
    rd_idx   = rd_en ? map_idx(rcnt) : idx_p1;
  end

  // Set and clear always target different banks, so both apply in the same cycle
  always_comb begin
    full_nxt = full;
    if (ld_en && (wcnt == 2'd3))
      full_nxt[wr_bank] = 1'b1;
    if (rd_en && (rcnt == 4'd15))
      full_nxt[rd_bank] = 1'b0;
  end

  // Write side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= 2'd0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (ld_en) begin
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'd3)
          wr_bank <= ~wr_bank;
      end
    end
  end

  // Read side: stage p1 is the sample presented on the buffer output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt       <= 4'd0;
      rd_bank    <= 1'b0;
      idx_p1     <= 4'd0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (rd_en) begin
        rcnt      <= rcnt + 4'd1;
        idx_p1    <= map_idx(rcnt);
        out_valid <= 1'b1;
        out_last  <= (rcnt == 4'd15);
        if (rcnt == 4'd15)
          rd_bank <= ~rd_bank;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_p_s_ctrl.sv
// Directed bench for p_s_ctrl: reset, single frame latency/order, backpressure, toggled ready, mid-run reset.
module tb_p_s_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       ld_en;
  logic       ld_bank;
  logic [1:0] ld_idx;
  logic       rd_en;
  logic       rd_bank;
  logic [3:0] rd_idx;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  p_s_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ld_en(ld_en), .ld_bank(ld_bank), .ld_idx(ld_idx),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_idx(rd_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_idx(input int n);
    logic [3:0] v;
    v = 4'(n);
`ifdef P_S_CTRL_BITREV_EN
    return {v[0], v[1], v[2], v[3]};
`else
    return v;
`endif
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    n_checks++; if (ld_en !== 1'b0) begin n_fail++; $display("FAIL reset_ld_en got=%b exp=0", ld_en); end
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (ld_idx !== 2'd0 || ld_bank !== 1'b0) begin n_fail++; $display("FAIL reset_ld_pos got=%0d/%b exp=0/0", ld_idx, ld_bank); end
    n_checks++; if (rd_idx !== 4'd0 || rd_bank !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pos got=%0d/%b exp=0/0", rd_idx, rd_bank); end
  endtask

  task automatic test_single_frame();
    int beats = 0, issues = 0, acc = 0, fd = 0, c3 = -10;
    logic prev_last = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_valid = (beats < 4); out_ready = 1'b1;
      #1;
      n_checks++; if (frame_done !== prev_last) begin n_fail++; $display("FAIL sf_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, prev_last); end
      if (frame_done) fd++;
      if (cyc == c3 + 1) begin
        n_checks++; if (rd_en !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL sf_latency_rd got rd_en=%b out_valid=%b exp 1/0", rd_en, out_valid); end
      end
      if (cyc == c3 + 2) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sf_latency_valid got=%b exp=1", out_valid); end
      end
      if (ld_en) begin
        n_checks++; if (ld_idx !== 2'(beats) || ld_bank !== 1'b0) begin n_fail++; $display("FAIL sf_ld got=%0d/%b exp=%0d/0", ld_idx, ld_bank, beats); end
        if (beats == 3) c3 = cyc;
        beats++;
      end
      if (rd_en) begin
        n_checks++; if (rd_idx !== exp_idx(issues) || rd_bank !== 1'b0) begin n_fail++; $display("FAIL sf_rd_idx n=%0d got=%0d/%b exp=%0d/0", issues, rd_idx, rd_bank, exp_idx(issues)); end
        issues++;
      end
      prev_last = 1'b0;
      if (out_valid) begin
        n_checks++; if (out_last !== (acc == 15)) begin n_fail++; $display("FAIL sf_out_last n=%0d got=%b exp=%b", acc, out_last, (acc == 15)); end
        if (out_ready) begin prev_last = (acc == 15); acc++; end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (acc != 16 || issues != 16) begin n_fail++; $display("FAIL sf_count got acc=%0d issued=%0d exp 16/16", acc, issues); end
    n_checks++; if (fd != 1) begin n_fail++; $display("FAIL sf_frame_done_count got=%0d exp=1", fd); end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      if (ld_en) begin
        n_checks++; if (ld_idx !== 2'(beats % 4) || ld_bank !== 1'((beats / 4) % 2)) begin n_fail++; $display("FAIL bp_ld n=%0d got=%0d/%b exp=%0d/%0d", beats, ld_idx, ld_bank, beats % 4, (beats / 4) % 2); end
        beats++;
      end
      @(posedge clk); #1;
    end
    #1;
    n_checks++; if (beats != 8) begin n_fail++; $display("FAIL bp_beats got=%0d exp=8", beats); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold got valid=%b rd_en=%b exp 1/0", out_valid, rd_en); end
    n_checks++; if (rd_idx !== 4'd0 || out_last !== 1'b0) begin n_fail++; $display("FAIL bp_idx got=%0d last=%b exp=0/0", rd_idx, out_last); end
  endtask

  task automatic test_toggle();
    int beats = 0, issues = 0, acc = 0, fd = 0, cyc = 0;
    logic prev_last = 1'b0;
    do_reset();
    while (acc < 48 && cyc < 400) begin
      in_valid = (beats < 12); out_ready = 1'(cyc % 2);
      #1;
      n_checks++; if (frame_done !== prev_last) begin n_fail++; $display("FAIL tg_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, prev_last); end
      if (frame_done) fd++;
      if (ld_en) begin
        n_checks++; if (ld_idx !== 2'(beats % 4) || ld_bank !== 1'((beats / 4) % 2)) begin n_fail++; $display("FAIL tg_ld n=%0d got=%0d/%b", beats, ld_idx, ld_bank); end
        beats++;
      end
      if (rd_en) begin
        n_checks++; if (rd_idx !== exp_idx(issues % 16) || rd_bank !== 1'((issues / 16) % 2)) begin n_fail++; $display("FAIL tg_rd n=%0d got=%0d/%b exp=%0d/%0d", issues, rd_idx, rd_bank, exp_idx(issues % 16), (issues / 16) % 2); end
        issues++;
      end
      prev_last = 1'b0;
      if (out_valid) begin
        n_checks++; if (out_last !== (acc % 16 == 15)) begin n_fail++; $display("FAIL tg_out_last n=%0d got=%b", acc, out_last); end
        if (out_ready) begin prev_last = (acc % 16 == 15); acc++; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (frame_done !== prev_last) begin n_fail++; $display("FAIL tg_last_done got=%b exp=%b", frame_done, prev_last); end
    if (frame_done) fd++;
    n_checks++; if (acc != 48 || issues != 48) begin n_fail++; $display("FAIL tg_count got acc=%0d issued=%0d exp 48/48", acc, issues); end
    n_checks++; if (fd != 3) begin n_fail++; $display("FAIL tg_frames got=%0d exp=3", fd); end
  endtask

  task automatic test_reset_mid();
    int beats = 0, issues = 0, acc = 0, cyc = 0;
    do_reset();
    // fill bank 0 and two beats of bank 1, then drain a few samples
    while (beats < 6 && cyc < 40) begin
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      if (ld_en) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rm_outputs got v=%b l=%b d=%b exp 0/0/0", out_valid, out_last, frame_done); end
    n_checks++; if (ld_en !== 1'b0 || rd_en !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_strobes got ld=%b rd=%b ir=%b exp 0/0/0", ld_en, rd_en, in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    beats = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (beats < 4); out_ready = 1'b1;
      #1;
      if (ld_en) begin
        if (beats == 0) begin
          n_checks++; if (ld_idx !== 2'd0 || ld_bank !== 1'b0) begin n_fail++; $display("FAIL rm_first_ld got=%0d/%b exp=0/0", ld_idx, ld_bank); end
        end
        beats++;
      end
      if (rd_en) begin
        if (issues == 0) begin
          n_checks++; if (rd_idx !== 4'd0 || rd_bank !== 1'b0) begin n_fail++; $display("FAIL rm_first_rd got=%0d/%b exp=0/0", rd_idx, rd_bank); end
        end
        issues++;
      end
      if (out_valid && out_ready) acc++;
      @(posedge clk); #1;
    end
    n_checks++; if (acc != 16 || issues != 16) begin n_fail++; $display("FAIL rm_count got acc=%0d issued=%0d exp 16/16", acc, issues); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
